vector_assembler: RTL and testbench
===================================

Name: vector_assembler

Overview:
- Inverse of the vector position detector: rebuilds a 32-bit bit-vector from a stream of bit-position codes in the detector's 6-bit encoding.
- Accepts position beats on a valid/ready interface and ORs each into an accumulator.
- Presents the finished vector, with its popcount, on a valid/ready output when the beat flagged last arrives.
- Sits downstream of the detector pipeline, or wherever a vector is carried serialized as positions.

Parameters:
- VEC_W, 32, vector width in bits.
- POS_W, 6, position code width; must be at least clog2(VEC_W)+1.
- MAX_BEATS, 32, maximum beats per vector before a forced close.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pos_in  in  POS_W  position code: 0..VEC_W-1 is a bit index; VEC_W is the empty code; greater than VEC_W is illegal.
- pos_valid  in  1  pos_in and pos_last are valid.
- pos_last  in  1  final beat of the current vector.
- pos_ready  out  1  block accepts a beat this cycle.
- vec_out  out  VEC_W  assembled vector.
- vec_cnt  out  POS_W  number of ones in vec_out.
- vec_valid  out  1  vec_out and vec_cnt are valid.
- vec_ready  in  1  downstream accepts the vector.
- clr_err  in  1  synchronous clear of err.
- err  out  2  sticky flags: [0] illegal code seen, [1] beat overflow.

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - state = ACC, accum = 0, beat_cnt = 0.
  - vec_out = 0, vec_cnt = 0, vec_valid = 0, err = 0.
  - pos_ready is 1 one cycle after rst deasserts.
- States:
  - ACC: pos_ready = 1, vec_valid = 0.
  - OUT: pos_ready = 0, vec_valid = 1.
- Beat accept = pos_valid & pos_ready, handled in ACC only:
  - pos_in < VEC_W: accum_next = accum | (1 << pos_in).
  - pos_in == VEC_W: accum unchanged (empty vector marker).
  - pos_in > VEC_W: accum unchanged; err[0] set next cycle.
  - A duplicate index is idempotent under the OR; it is not an error.
  - Every accepted beat increments beat_cnt, including empty and illegal beats.
- Close condition: an accepted beat with pos_last = 1, or an accepted beat that brings beat_cnt to MAX_BEATS.
  - On close: vec_out <= accum_next, vec_cnt <= popcount(accum_next), accum <= 0, beat_cnt <= 0, state <= OUT.
  - A forced close (beat_cnt reaches MAX_BEATS with pos_last = 0) also sets err[1].
  - A beat that hits MAX_BEATS with pos_last = 1 closes normally; err[1] is not set.
- Latency: the closing beat accepted at edge N gives vec_valid = 1 after edge N. No combinational path from pos_* to vec_*.
- In OUT:
  - vec_out and vec_cnt hold stable until the handshake.
  - vec_valid & vec_ready at edge M sets state to ACC after M, so pos_ready = 1 in cycle M+1.
- Throughput: one dead input cycle per vector when vec_ready is held high.
- pos_valid while in OUT is not accepted; the upstream source must hold the beat.
- Single-beat vector with pos_last = 1 on the first beat: OUT is entered directly.
- err:
  - Bits are sticky; clr_err clears both.
  - If clr_err and a new error event land in the same cycle, the set wins.
  - err is independent of the vector flow: a vector containing an illegal beat is still emitted.
- rst asserted mid-vector: partial accum is discarded, no vec_valid is produced, all outputs return to reset values immediately (asynchronous).
- vec_cnt range is 0..VEC_W and fits POS_W bits.

Decomposition:
- Shared package holds:
  - VEC_W = 32, POS_W = 6, EMPTY_CODE = 6'd32.
  - State encoding: ACC = 1'b0, OUT = 1'b1.
  - The err bit indices.
- The same package constants are reused by the detector bench for round-trip checks.
- One sub-module, vec_popcount: combinational adder tree, VEC_W in, POS_W out, instantiated once on accum_next.

Test Plan:
- Reset, then beats 3, 7, 31 (last on 31), vec_ready = 1 → vec_out = 0x80000088 and vec_cnt = 3 one cycle after the last beat; pos_ready low for exactly one cycle.
- Single beat 32 with last → vec_out = 0x00000000, vec_cnt = 0, err = 0.
- Beats 5, 5, 40, 0 (last) → vec_out = 0x00000021, vec_cnt = 2, err = 2'b01; then pulse clr_err → err = 0.
- 32 beats 0..31 with pos_last never set → forced close after beat 31: vec_out = 0xFFFFFFFF, vec_cnt = 32, err[1] = 1.
- Hold vec_ready = 0 for 5 cycles with pos_valid = 1 → vec_out stable, pos_ready = 0, no beat consumed; the next vector assembles correctly after vec_ready rises.
- Assert rst after beats 1 and 2 (no last) → vec_valid stays 0; the next vector with beat 9 (last) gives 0x00000200.
- Round trip: 1000 random vectors serialized to positions, checked against the detector's leading-index output and the reassembled vector.

Source files
------------

// File: rtl/vector_assembler_pkg.sv
// Shared constants and types for the vector assembler.
// Also reused by the position detector bench for round trips.
package vector_assembler_pkg;

  localparam int VEC_W = 32;
  localparam int POS_W = 6;
  localparam int MAX_BEATS = 32;

  localparam logic [POS_W-1:0] EMPTY_CODE = 6'd32;

  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_OVF = 1;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

endpackage

// File: rtl/vec_popcount.sv
// Combinational population count of a bit vector.
// Result width must hold VEC_W itself.
module vec_popcount #(
  parameter int VEC_W = 32,
  parameter int POS_W = 6
) (
  input  logic [VEC_W-1:0] vec,
  output logic [POS_W-1:0] cnt
);

  // Sum of all bits; synthesis reduces this to an adder tree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < VEC_W; i++) begin
      cnt = cnt + POS_W'(vec[i]);
    end
  end

endmodule

// File: rtl/vector_assembler.sv
// Rebuilds a bit vector from a stream of bit-position codes.
// Emits the vector and its popcount when the last beat lands.
module vector_assembler #(
  parameter int VEC_W = vector_assembler_pkg::VEC_W,
  parameter int POS_W = vector_assembler_pkg::POS_W,
  parameter int MAX_BEATS = vector_assembler_pkg::MAX_BEATS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] pos_in,
  input  logic             pos_valid,
  input  logic             pos_last,
  output logic             pos_ready,
  output logic [VEC_W-1:0] vec_out,
  output logic [POS_W-1:0] vec_cnt,
  output logic             vec_valid,
  input  logic             vec_ready,
  input  logic             clr_err,
  output logic [1:0]       err
);

  import vector_assembler_pkg::*;

  localparam int IDX_W = $clog2(VEC_W);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_e           state;
  state_e           state_d;
  logic [VEC_W-1:0] accum;
  logic [VEC_W-1:0] accum_d;
  logic [VEC_W-1:0] accum_next;
  logic [VEC_W-1:0] onehot;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_d;
  logic [CNT_W-1:0] beat_inc;
  logic [VEC_W-1:0] vec_out_d;
  logic [POS_W-1:0] vec_cnt_d;
  logic [POS_W-1:0] pc;
  logic [1:0]       err_d;
  logic             rdy_en;
  logic             accept;
  logic             illegal;
  logic             hit_max;
  logic             close;

  assign pos_ready  = (state == ACC) & rdy_en;
  assign vec_valid  = (state == OUT);
  assign accept     = pos_valid & pos_ready;
  assign accum_next = accum | onehot;
  assign beat_inc   = beat_cnt + CNT_W'(1);
  assign hit_max    = (beat_inc == CNT_W'(MAX_BEATS));
  assign close      = accept & (pos_last | hit_max);

  // Decode the position code into a one-hot bit or an error.
  always_comb begin
    onehot  = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (pos_in < POS_W'(VEC_W)):  onehot[pos_in[IDX_W-1:0]] = 1'b1;
      (pos_in == POS_W'(VEC_W)): illegal = 1'b0;
      default:                   illegal = 1'b1;
    endcase
  end

  vec_popcount #(
    .VEC_W(VEC_W),
    .POS_W(POS_W)
  ) u_pc (
    .vec(accum_next),
    .cnt(pc)
  );

  // Next-state: accumulate beats, close vectors, track errors.
  always_comb begin
    state_d   = state;
    accum_d   = accum;
    beat_d    = beat_cnt;
    vec_out_d = vec_out;
    vec_cnt_d = vec_cnt;
    err_d     = err;
    if (clr_err) err_d = '0;
    if (accept) begin
      accum_d = accum_next;
      beat_d  = beat_inc;
      if (illegal) err_d[ERR_ILLEGAL] = 1'b1;
      if (close) begin
        vec_out_d = accum_next;
        vec_cnt_d = pc;
        accum_d   = '0;
        beat_d    = '0;
        state_d   = OUT;
        if (!pos_last) err_d[ERR_OVF] = 1'b1;
      end
    end
    if (state == OUT && vec_ready) state_d = ACC;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACC;
      accum    <= '0;
      beat_cnt <= '0;
      vec_out  <= '0;
      vec_cnt  <= '0;
      err      <= '0;
      rdy_en   <= 1'b0;
    end else begin
      state    <= state_d;
      accum    <= accum_d;
      beat_cnt <= beat_d;
      vec_out  <= vec_out_d;
      vec_cnt  <= vec_cnt_d;
      err      <= err_d;
      rdy_en   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_assembler.sv
// Scoreboard bench for vector_assembler.
// Directed cases plus randomized vector round trips.
module tb_vector_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  pos_in = '0;
  logic        pos_valid = 1'b0;
  logic        pos_last = 1'b0;
  logic        pos_ready;
  logic [31:0] vec_out;
  logic [5:0]  vec_cnt;
  logic        vec_valid;
  logic        vec_ready = 1'b1;
  logic        clr_err = 1'b0;
  logic [1:0]  err;

  typedef struct {
    logic [31:0] v;
    logic [5:0]  c;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_vec = '0;
  int          cur_beats = 0;
  logic [1:0]  err_exp = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          rand_rdy = 1'b0;

  vector_assembler dut (
    .clk(clk),
    .rst(rst),
    .pos_in(pos_in),
    .pos_valid(pos_valid),
    .pos_last(pos_last),
    .pos_ready(pos_ready),
    .vec_out(vec_out),
    .vec_cnt(vec_cnt),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .clr_err(clr_err),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_t e;
    e.v = v;
    e.c = 6'($countones(v));
    sb.push_back(e);
  endtask

  // Reference: a vector is the set of legal indices seen since the
  // last close; it closes on last or on the 32nd beat.
  task automatic model_beat(input int p, input bit l);
    if (p < 32) cur_vec[p] = 1'b1;
    else if (p > 32) err_exp[0] = 1'b1;
    cur_beats++;
    if (l || cur_beats == 32) begin
      push_exp(cur_vec);
      if (!l) err_exp[1] = 1'b1;
      cur_vec = '0;
      cur_beats = 0;
    end
  endtask

  task automatic send_beat(input int p, input bit l);
    bit acc;
    int n;
    pos_valid = 1'b1;
    pos_in = 6'(p);
    pos_last = l;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = pos_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("beat_accept_timeout", 64'(acc), 64'd1);
    else model_beat(p, l);
    pos_valid = 1'b0;
    pos_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_err(input string name);
    @(negedge clk);
    check(name, 64'(err), 64'(err_exp));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    err_exp = '0;
  endtask

  // Monitor: each output handshake pops one expected vector.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vec_valid && vec_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_vec_valid", 64'(vec_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("vec_out", 64'(vec_out), 64'(e.v));
          check("vec_cnt", 64'(vec_cnt), 64'(e.c));
        end
      end
    end
  end

  // Random backpressure on the output side.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) vec_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int q[$];
    int sel;
    int j;
    int t;

    #2;
    check("rst_vec_out", 64'(vec_out), 64'd0);
    check("rst_vec_cnt", 64'(vec_cnt), 64'd0);
    check("rst_vec_valid", 64'(vec_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(pos_ready), 64'd1);

    // Basic vector and the one dead cycle.
    send_beat(3, 0);
    send_beat(7, 0);
    send_beat(31, 1);
    @(negedge clk);
    check("t1_valid", 64'(vec_valid), 64'd1);
    check("t1_ready_low", 64'(pos_ready), 64'd0);
    check("t1_vec", 64'(vec_out), 64'h8000_0088);
    check("t1_cnt", 64'(vec_cnt), 64'd3);
    @(negedge clk);
    check("t1_ready_back", 64'(pos_ready), 64'd1);
    check("t1_valid_drop", 64'(vec_valid), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // Empty vector.
    send_beat(32, 1);
    drain();
    check_err("t2_err");

    // Duplicate plus illegal code.
    send_beat(5, 0);
    send_beat(5, 0);
    send_beat(40, 0);
    send_beat(0, 1);
    drain();
    check_err("t3_err_set");
    pulse_clr();
    check_err("t3_err_clr");

    // Forced close on beat count.
    for (int i = 0; i < 32; i++) send_beat(i, 0);
    drain();
    check_err("t4_err_ovf");
    pulse_clr();

    // Output stall with a beat waiting.
    vec_ready = 1'b0;
    send_beat(1, 0);
    send_beat(2, 1);
    pos_valid = 1'b1;
    pos_in = 6'd4;
    pos_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_ready_low", 64'(pos_ready), 64'd0);
      check("t5_valid", 64'(vec_valid), 64'd1);
      check("t5_hold", 64'(vec_out), 64'h6);
    end
    @(posedge clk);
    #1;
    vec_ready = 1'b1;
    send_beat(4, 1);
    drain();

    // Reset mid-vector discards the partial vector.
    send_beat(1, 0);
    send_beat(2, 0);
    rst = 1'b1;
    #1;
    check("t6_valid_rst", 64'(vec_valid), 64'd0);
    check("t6_ready_rst", 64'(pos_ready), 64'd0);
    cur_vec = '0;
    cur_beats = 0;
    err_exp = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_beat(9, 1);
    drain();
    check_err("t6_err");

    // Random round trips.
    rand_rdy = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) v = '0;
      else if (sel == 1) v = '1;
      else if (sel < 6) v = $urandom & $urandom & $urandom;
      else v = $urandom;
      q.delete();
      for (int i = 0; i < 32; i++) if (v[i]) q.push_back(i);
      if (q.size() == 0) q.push_back(32);
      if (q.size() < 32 && $urandom_range(0, 3) == 0)
        q.push_back(q[$urandom_range(0, q.size() - 1)]);
      if (q.size() < 32 && $urandom_range(0, 4) == 0) q.push_back(32);
      for (int i = q.size() - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = q[i];
        q[i] = q[j];
        q[j] = t;
      end
      for (int i = 0; i < q.size(); i++)
        send_beat(q[i], i == q.size() - 1);
    end
    rand_rdy = 1'b0;
    vec_ready = 1'b1;
    drain();
    check_err("rand_err");
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
